sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller command port between display reads, draw reads/writes
// and periodic refresh, and steers read data back to its requester by tag.
module sdram_arbiter #(
  parameter int REFRESH_INTERVAL = 780,
  parameter int DRAW_MIN_SLOT    = 8,
  parameter int TAG_DEPTH        = 4
) (
  input  logic        clk_draw,
  input  logic        rst_draw,
  input  logic        disp_req_valid,
  output logic        disp_req_ready,
  input  logic [23:0] disp_req_addr,
  output logic        disp_rsp_valid,
  output logic [15:0] disp_rsp_data,
  input  logic        draw_req_valid,
  output logic        draw_req_ready,
  input  logic        draw_req_write,
  input  logic [23:0] draw_req_addr,
  input  logic [15:0] draw_req_wdata,
  output logic        draw_rsp_valid,
  output logic [15:0] draw_rsp_data,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic [1:0]  mem_cmd_op,
  output logic [23:0] mem_cmd_addr,
  output logic [15:0] mem_cmd_wdata,
  input  logic        mem_rsp_valid,
  input  logic [15:0] mem_rsp_data,
  output logic        refresh_overrun
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CMD  = 1'b1;

  localparam logic [1:0] OP_READ    = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_REFRESH = 2'b10;

  localparam int TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int SW = (DRAW_MIN_SLOT > 0) ? $clog2(DRAW_MIN_SLOT + 1) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  localparam logic [TW-1:0] TIMER_RELOAD = TW'(REFRESH_INTERVAL - 1);
  localparam logic [SW-1:0] STREAK_LIMIT = SW'(DRAW_MIN_SLOT);
  localparam logic [CW-1:0] TAG_FULL     = CW'(TAG_DEPTH);
  localparam logic [PW-1:0] PTR_LAST     = PW'(TAG_DEPTH - 1);

  logic [0:0]           state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [2:0]           refresh_pending_q, refresh_pending_d;
  logic                 refresh_overrun_q, refresh_overrun_d;
  logic [SW-1:0]        streak_q, streak_d;
  logic [TAG_DEPTH-1:0] tag_mem_q, tag_mem_d;
  logic [PW-1:0]        tag_rd_ptr_q, tag_rd_ptr_d;
  logic [PW-1:0]        tag_wr_ptr_q, tag_wr_ptr_d;
  logic [CW-1:0]        tag_count_q, tag_count_d;
  logic                 mem_cmd_valid_q, mem_cmd_valid_d;
  logic [1:0]           mem_cmd_op_q, mem_cmd_op_d;
  logic [23:0]          mem_cmd_addr_q, mem_cmd_addr_d;
  logic [15:0]          mem_cmd_wdata_q, mem_cmd_wdata_d;
  logic                 disp_rsp_valid_q, disp_rsp_valid_d;
  logic [15:0]          disp_rsp_data_q, disp_rsp_data_d;
  logic                 draw_rsp_valid_q, draw_rsp_valid_d;
  logic [15:0]          draw_rsp_data_q, draw_rsp_data_d;

  logic timer_tick;
  logic read_room;
  logic draw_eligible;
  logic disp_eligible;
  logic draw_forced;
  logic grant_refresh;
  logic grant_draw;
  logic grant_disp;
  logic grant_read;
  logic tag_push;
  logic tag_pop;
  logic pop_owner;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
  endfunction

  // A draw write needs no tag slot, so only reads are held back by a full tag FIFO.
  always_comb begin
    timer_tick    = (timer_q == '0);
    read_room     = (tag_count_q < TAG_FULL);
    draw_eligible = draw_req_valid && (draw_req_write || read_room);
    disp_eligible = disp_req_valid && read_room;
    draw_forced   = (streak_q == STREAK_LIMIT);
    grant_refresh = 1'b0;
    grant_draw    = 1'b0;
    grant_disp    = 1'b0;
    if ((state_q == IDLE) && !rst_draw) begin
      if (refresh_pending_q != 3'd0) begin
        grant_refresh = 1'b1;
      end else if (draw_forced && draw_eligible) begin
        grant_draw = 1'b1;
      end else if (disp_eligible) begin
        grant_disp = 1'b1;
      end else if (draw_eligible) begin
        grant_draw = 1'b1;
      end
    end
    grant_read = grant_disp || (grant_draw && !draw_req_write);
  end

  assign disp_req_ready = grant_disp;
  assign draw_req_ready = grant_draw;

  always_comb begin
    state_d         = state_q;
    mem_cmd_valid_d = mem_cmd_valid_q;
    mem_cmd_op_d    = mem_cmd_op_q;
    mem_cmd_addr_d  = mem_cmd_addr_q;
    mem_cmd_wdata_d = mem_cmd_wdata_q;
    if (state_q == CMD) begin
      if (mem_cmd_valid_q && mem_cmd_ready) begin
        state_d         = IDLE;
        mem_cmd_valid_d = 1'b0;
      end
    end else if (grant_refresh) begin
      state_d         = CMD;
      mem_cmd_valid_d = 1'b1;
      mem_cmd_op_d    = OP_REFRESH;
      mem_cmd_addr_d  = '0;
      mem_cmd_wdata_d = '0;
    end else if (grant_disp) begin
      state_d         = CMD;
      mem_cmd_valid_d = 1'b1;
      mem_cmd_op_d    = OP_READ;
      mem_cmd_addr_d  = disp_req_addr;
      mem_cmd_wdata_d = '0;
    end else if (grant_draw) begin
      state_d         = CMD;
      mem_cmd_valid_d = 1'b1;
      mem_cmd_op_d    = draw_req_write ? OP_WRITE : OP_READ;
      mem_cmd_addr_d  = draw_req_addr;
      mem_cmd_wdata_d = draw_req_wdata;
    end
  end

  // Responses arrive in command order; a response with no outstanding tag is discarded.
  always_comb begin
    tag_push         = grant_read;
    tag_pop          = mem_rsp_valid && (tag_count_q != '0);
    pop_owner        = tag_mem_q[tag_rd_ptr_q];
    tag_mem_d        = tag_mem_q;
    tag_rd_ptr_d     = tag_rd_ptr_q;
    tag_wr_ptr_d     = tag_wr_ptr_q;
    if (tag_push) begin
      tag_mem_d[tag_wr_ptr_q] = grant_draw;
      tag_wr_ptr_d            = ptr_next(tag_wr_ptr_q);
    end
    if (tag_pop) begin
      tag_rd_ptr_d = ptr_next(tag_rd_ptr_q);
    end
    tag_count_d      = tag_count_q + CW'(tag_push) - CW'(tag_pop);
    disp_rsp_valid_d = tag_pop && !pop_owner;
    draw_rsp_valid_d = tag_pop && pop_owner;
    disp_rsp_data_d  = disp_rsp_valid_d ? mem_rsp_data : disp_rsp_data_q;
    draw_rsp_data_d  = draw_rsp_valid_d ? mem_rsp_data : draw_rsp_data_q;
  end

  // A tick and a grant together cancel; a tick onto a full backlog is lost and flagged.
  always_comb begin
    timer_d           = timer_tick ? TIMER_RELOAD : timer_q - TW'(1);
    refresh_pending_d = refresh_pending_q;
    refresh_overrun_d = refresh_overrun_q;
    if (timer_tick && (refresh_pending_q == 3'd7)) begin
      refresh_overrun_d = 1'b1;
    end
    if (timer_tick && !grant_refresh && (refresh_pending_q != 3'd7)) begin
      refresh_pending_d = refresh_pending_q + 3'd1;
    end else if (!timer_tick && grant_refresh) begin
      refresh_pending_d = refresh_pending_q - 3'd1;
    end
    streak_d = streak_q;
    if (!draw_req_valid || grant_draw) begin
      streak_d = '0;
    end else if (grant_disp) begin
      streak_d = streak_q + SW'(1);
    end
  end

  always_ff @(posedge clk_draw) begin
    if (rst_draw) begin
      state_q           <= IDLE;
      timer_q           <= TIMER_RELOAD;
      refresh_pending_q <= '0;
      refresh_overrun_q <= 1'b0;
      streak_q          <= '0;
      tag_mem_q         <= '0;
      tag_rd_ptr_q      <= '0;
      tag_wr_ptr_q      <= '0;
      tag_count_q       <= '0;
      mem_cmd_valid_q   <= 1'b0;
      mem_cmd_op_q      <= '0;
      mem_cmd_addr_q    <= '0;
      mem_cmd_wdata_q   <= '0;
      disp_rsp_valid_q  <= 1'b0;
      disp_rsp_data_q   <= '0;
      draw_rsp_valid_q  <= 1'b0;
      draw_rsp_data_q   <= '0;
    end else begin
      state_q           <= state_d;
      timer_q           <= timer_d;
      refresh_pending_q <= refresh_pending_d;
      refresh_overrun_q <= refresh_overrun_d;
      streak_q          <= streak_d;
      tag_mem_q         <= tag_mem_d;
      tag_rd_ptr_q      <= tag_rd_ptr_d;
      tag_wr_ptr_q      <= tag_wr_ptr_d;
      tag_count_q       <= tag_count_d;
      mem_cmd_valid_q   <= mem_cmd_valid_d;
      mem_cmd_op_q      <= mem_cmd_op_d;
      mem_cmd_addr_q    <= mem_cmd_addr_d;
      mem_cmd_wdata_q   <= mem_cmd_wdata_d;
      disp_rsp_valid_q  <= disp_rsp_valid_d;
      disp_rsp_data_q   <= disp_rsp_data_d;
      draw_rsp_valid_q  <= draw_rsp_valid_d;
      draw_rsp_data_q   <= draw_rsp_data_d;
    end
  end

  assign mem_cmd_valid   = mem_cmd_valid_q;
  assign mem_cmd_op      = mem_cmd_op_q;
  assign mem_cmd_addr    = mem_cmd_addr_q;
  assign mem_cmd_wdata   = mem_cmd_wdata_q;
  assign disp_rsp_valid  = disp_rsp_valid_q;
  assign disp_rsp_data   = disp_rsp_data_q;
  assign draw_rsp_valid  = draw_rsp_valid_q;
  assign draw_rsp_data   = draw_rsp_data_q;
  assign refresh_overrun = refresh_overrun_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: a transaction-level model (queues, counters) checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_sdram_arbiter;

  localparam int RI = 64;
  localparam int DMS = 8;
  localparam int TD = 4;

  localparam int G_NONE = 0;
  localparam int G_REF  = 1;
  localparam int G_DISP = 2;
  localparam int G_DRAW = 3;

  logic        clk_draw = 1'b0;
  logic        rst_draw = 1'b1;
  logic        disp_req_valid = 1'b0;
  logic        disp_req_ready;
  logic [23:0] disp_req_addr = '0;
  logic        disp_rsp_valid;
  logic [15:0] disp_rsp_data;
  logic        draw_req_valid = 1'b0;
  logic        draw_req_ready;
  logic        draw_req_write = 1'b0;
  logic [23:0] draw_req_addr = '0;
  logic [15:0] draw_req_wdata = '0;
  logic        draw_rsp_valid;
  logic [15:0] draw_rsp_data;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready = 1'b0;
  logic [1:0]  mem_cmd_op;
  logic [23:0] mem_cmd_addr;
  logic [15:0] mem_cmd_wdata;
  logic        mem_rsp_valid = 1'b0;
  logic [15:0] mem_rsp_data = '0;
  logic        refresh_overrun;

  sdram_arbiter #(
    .REFRESH_INTERVAL(RI),
    .DRAW_MIN_SLOT(DMS),
    .TAG_DEPTH(TD)
  ) dut (
    .clk_draw(clk_draw),
    .rst_draw(rst_draw),
    .disp_req_valid(disp_req_valid),
    .disp_req_ready(disp_req_ready),
    .disp_req_addr(disp_req_addr),
    .disp_rsp_valid(disp_rsp_valid),
    .disp_rsp_data(disp_rsp_data),
    .draw_req_valid(draw_req_valid),
    .draw_req_ready(draw_req_ready),
    .draw_req_write(draw_req_write),
    .draw_req_addr(draw_req_addr),
    .draw_req_wdata(draw_req_wdata),
    .draw_rsp_valid(draw_rsp_valid),
    .draw_rsp_data(draw_rsp_data),
    .mem_cmd_valid(mem_cmd_valid),
    .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_op(mem_cmd_op),
    .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_wdata(mem_cmd_wdata),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .refresh_overrun(refresh_overrun)
  );

  always #5 clk_draw = ~clk_draw;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  // Reference model state: one outstanding command, a queue of read owners, counters.
  bit          m_busy;
  logic [1:0]  m_op;
  logic [23:0] m_addr;
  logic [15:0] m_wdata;
  int          m_tags[$];
  int          m_pending;
  int          m_timer;
  int          m_streak;
  bit          m_overrun;
  bit          m_disp_v;
  bit          m_draw_v;
  logic [15:0] m_disp_d;
  logic [15:0] m_draw_d;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    bit room;
    bit draw_ok;
    bit disp_ok;
    if (rst_draw || m_busy) return G_NONE;
    if (m_pending > 0) return G_REF;
    room    = (m_tags.size() < TD);
    draw_ok = draw_req_valid && (draw_req_write || room);
    disp_ok = disp_req_valid && room;
    if (draw_ok && m_streak >= DMS) return G_DRAW;
    if (disp_ok) return G_DISP;
    if (draw_ok) return G_DRAW;
    return G_NONE;
  endfunction

  always @(posedge clk_draw) begin
    int g;
    bit tick;
    if (rst_draw) begin
      m_busy = 0; m_op = '0; m_addr = '0; m_wdata = '0;
      m_tags.delete();
      m_pending = 0; m_timer = RI - 1; m_streak = 0; m_overrun = 0;
      m_disp_v = 0; m_draw_v = 0; m_disp_d = '0; m_draw_d = '0;
      check_en = 1'b1;
    end else begin
      g = model_grant();
      m_disp_v = 0;
      m_draw_v = 0;
      if (mem_rsp_valid && m_tags.size() > 0) begin
        if (m_tags.pop_front() == 0) begin
          m_disp_v = 1; m_disp_d = mem_rsp_data;
        end else begin
          m_draw_v = 1; m_draw_d = mem_rsp_data;
        end
      end
      if (g == G_DISP) m_tags.push_back(0);
      if (g == G_DRAW && !draw_req_write) m_tags.push_back(1);
      tick = (m_timer == 0);
      m_timer = tick ? RI - 1 : m_timer - 1;
      if (tick && m_pending == 7) m_overrun = 1;
      m_pending = m_pending + (tick ? 1 : 0) - ((g == G_REF) ? 1 : 0);
      if (m_pending > 7) m_pending = 7;
      if (!draw_req_valid || g == G_DRAW) m_streak = 0;
      else if (g == G_DISP) m_streak = m_streak + 1;
      if (m_busy) begin
        if (mem_cmd_ready) m_busy = 0;
      end else if (g != G_NONE) begin
        m_busy = 1;
        if (g == G_REF) begin
          m_op = 2'b10; m_addr = '0; m_wdata = '0;
        end else if (g == G_DISP) begin
          m_op = 2'b00; m_addr = disp_req_addr; m_wdata = '0;
        end else begin
          m_op = draw_req_write ? 2'b01 : 2'b00;
          m_addr = draw_req_addr;
          m_wdata = draw_req_wdata;
        end
      end
    end
  end

  always @(negedge clk_draw) begin
    int g;
    if (check_en) begin
      g = model_grant();
      check_output("disp_req_ready", disp_req_ready, (g == G_DISP));
      check_output("draw_req_ready", draw_req_ready, (g == G_DRAW));
      check_output("mem_cmd_valid", mem_cmd_valid, m_busy);
      if (m_busy) begin
        check_output("mem_cmd_op", mem_cmd_op, m_op);
        check_output("mem_cmd_addr", mem_cmd_addr, m_addr);
        if (m_op != 2'b00) check_output("mem_cmd_wdata", mem_cmd_wdata, m_wdata);
      end
      check_output("disp_rsp_valid", disp_rsp_valid, m_disp_v);
      if (m_disp_v) check_output("disp_rsp_data", disp_rsp_data, m_disp_d);
      check_output("draw_rsp_valid", draw_rsp_valid, m_draw_v);
      if (m_draw_v) check_output("draw_rsp_data", draw_rsp_data, m_draw_d);
      check_output("refresh_overrun", refresh_overrun, m_overrun);
    end
  end

  task automatic step();
    @(posedge clk_draw);
    #1;
  endtask

  task automatic drive_idle();
    disp_req_valid = 0; draw_req_valid = 0; draw_req_write = 0;
    mem_cmd_ready = 0; mem_rsp_valid = 0;
  endtask

  task automatic do_reset();
    rst_draw = 1;
    drive_idle();
    step();
    step();
    rst_draw = 0;
  endtask

  task automatic apply_stimulus(input bit is_draw, input bit wr, input logic [23:0] addr,
                                input logic [15:0] wd);
    bit done;
    done = 0;
    if (is_draw) begin
      draw_req_valid = 1; draw_req_write = wr; draw_req_addr = addr; draw_req_wdata = wd;
    end else begin
      disp_req_valid = 1; disp_req_addr = addr;
    end
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk_draw);
      done = is_draw ? draw_req_ready : disp_req_ready;
      step();
    end
    disp_req_valid = 0;
    draw_req_valid = 0;
    check_output("request accepted", done, 1);
  endtask

  int kinds[18];
  logic [1:0] ops[9];
  logic [23:0] addrs[9];
  int n;
  int cyc;

  initial begin
    // Reset holds both readies low even with both requesters active.
    rst_draw = 1;
    drive_idle();
    disp_req_valid = 1;
    draw_req_valid = 1;
    step();
    step();
    @(negedge clk_draw);
    check_output("rst disp_req_ready", disp_req_ready, 0);
    check_output("rst draw_req_ready", draw_req_ready, 0);
    check_output("rst mem_cmd_valid", mem_cmd_valid, 0);
    check_output("rst mem_cmd_op", mem_cmd_op, 0);
    check_output("rst mem_cmd_addr", mem_cmd_addr, 0);
    check_output("rst disp_rsp_valid", disp_rsp_valid, 0);
    check_output("rst draw_rsp_data", draw_rsp_data, 0);
    check_output("rst refresh_overrun", refresh_overrun, 0);

    // Single display read and its response.
    do_reset();
    mem_cmd_ready = 1; disp_req_valid = 1; disp_req_addr = 24'h000100;
    @(negedge clk_draw);
    check_output("t1 disp_req_ready", disp_req_ready, 1);
    step();
    disp_req_valid = 0;
    @(negedge clk_draw);
    check_output("t1 mem_cmd_valid", mem_cmd_valid, 1);
    check_output("t1 mem_cmd_op", mem_cmd_op, 2'b00);
    check_output("t1 mem_cmd_addr", mem_cmd_addr, 24'h000100);
    step();
    @(negedge clk_draw);
    check_output("t1 cmd retired", mem_cmd_valid, 0);
    step();
    mem_rsp_valid = 1; mem_rsp_data = 16'hBEEF;
    step();
    mem_rsp_valid = 0;
    @(negedge clk_draw);
    check_output("t1 disp_rsp_valid", disp_rsp_valid, 1);
    check_output("t1 disp_rsp_data", disp_rsp_data, 16'hBEEF);
    check_output("t1 draw_rsp_valid", draw_rsp_valid, 0);
    step();
    @(negedge clk_draw);
    check_output("t1 disp_rsp one cycle", disp_rsp_valid, 0);

    // Starvation guard: eight display grants, then one draw grant.
    do_reset();
    mem_cmd_ready = 1; mem_rsp_valid = 1; mem_rsp_data = 16'h5A5A;
    disp_req_valid = 1; disp_req_addr = 24'h001000;
    draw_req_valid = 1; draw_req_write = 1; draw_req_addr = 24'h002000; draw_req_wdata = 16'h0F0F;
    n = 0;
    cyc = 0;
    while (n < 18 && cyc < 100) begin
      @(negedge clk_draw);
      if (disp_req_ready) begin kinds[n] = G_DISP; n++; end
      else if (draw_req_ready) begin kinds[n] = G_DRAW; n++; end
      step();
      cyc++;
    end
    check_output("t2 grant count", n, 18);
    for (int i = 0; i < n; i++)
      check_output($sformatf("t2 grant %0d", i), kinds[i], ((i % 9) == 8) ? G_DRAW : G_DISP);

    // Controller back-pressure keeps the command stable and blocks new grants.
    do_reset();
    disp_req_valid = 1; disp_req_addr = 24'h0ABCDE;
    step();
    draw_req_valid = 1; draw_req_write = 1; draw_req_addr = 24'h0C0DE0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_draw);
      check_output("t3 mem_cmd_valid", mem_cmd_valid, 1);
      check_output("t3 mem_cmd_op", mem_cmd_op, 2'b00);
      check_output("t3 mem_cmd_addr", mem_cmd_addr, 24'h0ABCDE);
      check_output("t3 disp_req_ready", disp_req_ready, 0);
      check_output("t3 draw_req_ready", draw_req_ready, 0);
      step();
    end
    mem_cmd_ready = 1; disp_req_valid = 0; draw_req_valid = 0;
    step();
    @(negedge clk_draw);
    check_output("t3 cmd retired", mem_cmd_valid, 0);

    // Tag FIFO full: reads blocked, writes still pass; responses route in order.
    do_reset();
    mem_cmd_ready = 1;
    apply_stimulus(0, 0, 24'h000010, 16'h0000);
    apply_stimulus(1, 0, 24'h000020, 16'h0000);
    apply_stimulus(0, 0, 24'h000030, 16'h0000);
    apply_stimulus(1, 0, 24'h000040, 16'h0000);
    disp_req_valid = 1; disp_req_addr = 24'h000050;
    draw_req_valid = 1; draw_req_write = 1; draw_req_addr = 24'h000060; draw_req_wdata = 16'h1234;
    step();
    @(negedge clk_draw);
    check_output("t4 write granted", draw_req_ready, 1);
    check_output("t4 read blocked", disp_req_ready, 0);
    step();
    draw_req_valid = 0;
    @(negedge clk_draw);
    check_output("t4 write op", mem_cmd_op, 2'b01);
    check_output("t4 write addr", mem_cmd_addr, 24'h000060);
    check_output("t4 write wdata", mem_cmd_wdata, 16'h1234);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk_draw);
      check_output("t4 fifth read blocked", disp_req_ready, 0);
    end
    disp_req_valid = 0;
    mem_rsp_valid = 1;
    for (int i = 0; i < 4; i++) begin
      mem_rsp_data = 16'hA000 + 16'(i);
      step();
      if (i == 3) mem_rsp_valid = 0;
      @(negedge clk_draw);
      check_output("t4 disp_rsp_valid", disp_rsp_valid, ((i % 2) == 0));
      check_output("t4 draw_rsp_valid", draw_rsp_valid, ((i % 2) == 1));
      check_output("t4 rsp_data", ((i % 2) == 0) ? disp_rsp_data : draw_rsp_data, 16'hA000 + 16'(i));
    end
    mem_rsp_valid = 1; mem_rsp_data = 16'hDEAD;
    step();
    mem_rsp_valid = 0;
    @(negedge clk_draw);
    check_output("t4 orphan disp_rsp", disp_rsp_valid, 0);
    check_output("t4 orphan draw_rsp", draw_rsp_valid, 0);

    // Refresh backlog saturates while the controller stalls, then drains first.
    do_reset();
    repeat (590) step();
    @(negedge clk_draw);
    check_output("t5 overrun set", refresh_overrun, 1);
    check_output("t5 stuck refresh op", mem_cmd_op, 2'b10);
    step();
    disp_req_valid = 1; disp_req_addr = 24'h000777; mem_cmd_ready = 1;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_draw);
      if (mem_cmd_valid && n < 9) begin
        ops[n] = mem_cmd_op; addrs[n] = mem_cmd_addr; n++;
      end
      step();
      if (n == 9) disp_req_valid = 0;
    end
    disp_req_valid = 0;
    check_output("t5 command count", n, 9);
    for (int i = 0; i < n; i++) begin
      check_output($sformatf("t5 op %0d", i), ops[i], (i < 8) ? 2'b10 : 2'b00);
      check_output($sformatf("t5 addr %0d", i), addrs[i], (i < 8) ? 24'h0 : 24'h000777);
    end
    @(negedge clk_draw);
    check_output("t5 overrun sticky", refresh_overrun, 1);
    do_reset();
    @(negedge clk_draw);
    check_output("t5 overrun cleared", refresh_overrun, 0);

    // Randomized traffic, including occasional resets mid-command.
    for (int phase = 0; phase < 2; phase++) begin
      for (int c = 0; c < 1500; c++) begin
        rst_draw       = ($urandom_range(0, 299) == 0);
        disp_req_valid = ($urandom_range(0, 9) < 5);
        disp_req_addr  = 24'($urandom);
        draw_req_valid = ($urandom_range(0, 9) < 5);
        draw_req_write = ($urandom_range(0, 1) == 0);
        draw_req_addr  = 24'($urandom);
        draw_req_wdata = 16'($urandom);
        mem_cmd_ready  = ($urandom_range(0, 9) < ((phase == 0) ? 6 : 3));
        mem_rsp_valid  = ($urandom_range(0, 9) < ((phase == 0) ? 4 : 1));
        mem_rsp_data   = 16'($urandom);
        step();
      end
    end

    drive_idle();
    rst_draw = 0;
    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
